// File: rtl/apu_pkg.sv
// apu_pkg -- constants and helpers shared by the APU frame sequencer and
// the channel generators.
//   LEN_STEP_MASK / SWEEP_STEP_MASK / ENV_STEP_MASK : one bit per sequencer
//     step (bit n = step n) marking the steps that fire each strobe.
//   NUM_CH          : number of sound channels.
//   CLK_DIV_DEFAULT : default clk cycles per 512 Hz sequencer step.
package apu_pkg;

  localparam logic [7:0]  LEN_STEP_MASK   = 8'b0101_0101;
  localparam logic [7:0]  SWEEP_STEP_MASK = 8'b0100_0100;
  localparam logic [7:0]  ENV_STEP_MASK   = 8'b1000_0000;

  localparam int unsigned NUM_CH          = 4;
  localparam int unsigned CLK_DIV_DEFAULT = 8192;

  typedef struct packed {
    logic len;
    logic sweep;
    logic env;
  } seq_strobe_t;

  // Strobes fired by the given sequencer step.
  function automatic seq_strobe_t decode_step(input logic [2:0] s);
    seq_strobe_t r;
    r.len   = LEN_STEP_MASK[s];
    r.sweep = SWEEP_STEP_MASK[s];
    r.env   = ENV_STEP_MASK[s];
    return r;
  endfunction

endpackage

// File: rtl/apu_trigger_ctrl.sv
// apu_trigger_ctrl -- per-channel trigger edge detection and playing status.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   master_en         : APU power; 0 clears outputs and ignores events
//   trigger_in[N]     : level-sensitive initialize bits
//   length_expire[N]  : one-cycle length-counter expiry pulses
//   trig_pulse[N]     : one-cycle strobe on a trigger rising edge
//   ch_active[N]      : channel playing status
module apu_trigger_ctrl
  import apu_pkg::*;
#(
  parameter int unsigned N = NUM_CH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         master_en,
  input  logic [N-1:0] trigger_in,
  input  logic [N-1:0] length_expire,
  output logic [N-1:0] trig_pulse,
  output logic [N-1:0] ch_active
);

  logic [N-1:0] trig_prev;
  logic [N-1:0] trig_edge;

  assign trig_edge = trigger_in & ~trig_prev;

  // Edge history keeps tracking while powered down, so a trigger held high
  // across power-up does not register as a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) trig_prev <= '0;
    else       trig_prev <= trigger_in;
  end

  // A trigger edge wins over a coincident length expiry.
  always_ff @(posedge clk) begin
    if (reset || !master_en) begin
      trig_pulse <= '0;
      ch_active  <= '0;
    end else begin
      trig_pulse <= trig_edge;
      ch_active  <= trig_edge | (ch_active & ~length_expire);
    end
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer -- 512 Hz frame sequencer producing the length (256 Hz),
// sweep (128 Hz) and envelope (64 Hz) strobes, plus channel trigger control.
// Configuration macro: APU_SEQ_EXT_TICK_EN -- when defined, steps are driven
// by tick_512_in (gated by master_en) instead of the internal prescaler.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   master_en      : APU power; 0 halts and clears the block
//   tick_512_in    : external step request (APU_SEQ_EXT_TICK_EN only)
//   trigger_in[4]  : per-channel initialize bits (level)
//   length_expire[4]: per-channel length expiry pulses
//   length_tick, sweep_tick, env_tick : registered one-cycle strobes
//   step[3]        : index of the next step to execute
//   trig_pulse[4]  : one-cycle trigger strobes
//   ch_active[4]   : per-channel playing status
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              master_en,
  input  logic              tick_512_in,
  input  logic [NUM_CH-1:0] trigger_in,
  input  logic [NUM_CH-1:0] length_expire,
  output logic              length_tick,
  output logic              sweep_tick,
  output logic              env_tick,
  output logic [2:0]        step,
  output logic [NUM_CH-1:0] trig_pulse,
  output logic [NUM_CH-1:0] ch_active
);

  logic        step_tick;
  seq_strobe_t strobe_next;

`ifdef APU_SEQ_EXT_TICK_EN
  localparam int unsigned UNUSED_CLK_DIV = CLK_DIV;

  assign step_tick = tick_512_in & master_en;
`else
  localparam logic [15:0] PRESC_TOP = 16'(CLK_DIV - 1);

  logic [15:0] presc;
  logic        unused_tick_512_in;

  assign unused_tick_512_in = tick_512_in;
  assign step_tick          = master_en && (presc == PRESC_TOP);

  always_ff @(posedge clk) begin
    if (reset || !master_en) presc <= '0;
    else if (step_tick)      presc <= '0;
    else                     presc <= presc + 16'd1;
  end
`endif

  assign strobe_next = decode_step(step);

  // Strobes decode the step being executed; step then points at the next one.
  always_ff @(posedge clk) begin
    if (reset || !master_en) begin
      step        <= '0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end else begin
      length_tick <= step_tick & strobe_next.len;
      sweep_tick  <= step_tick & strobe_next.sweep;
      env_tick    <= step_tick & strobe_next.env;
      if (step_tick) step <= step + 3'd1;
    end
  end

  apu_trigger_ctrl #(
    .N (NUM_CH)
  ) u_trigger_ctrl (
    .clk           (clk),
    .reset         (reset),
    .master_en     (master_en),
    .trigger_in    (trigger_in),
    .length_expire (length_expire),
    .trig_pulse    (trig_pulse),
    .ch_active     (ch_active)
  );

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer -- directed self-checking bench for
// apu_frame_sequencer with CLK_DIV=4. Build with APU_SEQ_EXT_TICK_EN defined
// to exercise the external step-tick source.
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       master_en;
  logic       tick_512_in;
  logic [3:0] trigger_in;
  logic [3:0] length_expire;
  logic       length_tick;
  logic       sweep_tick;
  logic       env_tick;
  logic [2:0] step;
  logic [3:0] trig_pulse;
  logic [3:0] ch_active;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  apu_frame_sequencer #(
    .CLK_DIV (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .master_en     (master_en),
    .tick_512_in   (tick_512_in),
    .trigger_in    (trigger_in),
    .length_expire (length_expire),
    .length_tick   (length_tick),
    .sweep_tick    (sweep_tick),
    .env_tick      (env_tick),
    .step          (step),
    .trig_pulse    (trig_pulse),
    .ch_active     (ch_active)
  );

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_len"},   8'(length_tick), 8'd0);
    chk({tag, "_sweep"}, 8'(sweep_tick),  8'd0);
    chk({tag, "_env"},   8'(env_tick),    8'd0);
    chk({tag, "_step"},  8'(step),        8'd0);
    chk({tag, "_tpls"},  8'(trig_pulse),  8'd0);
    chk({tag, "_act"},   8'(ch_active),   8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; master_en = 1'b0; tick_512_in = 1'b0;
    trigger_in = '0; length_expire = '0;

    // Reset state
    cyc(2);
    chk_all_zero("reset");

    // Trigger handling with the block powered
    reset = 1'b0; master_en = 1'b1;
    cyc(1);
    trigger_in = 4'b0010;
    cyc(1);
    chk("trig1_pulse", 8'(trig_pulse), 8'h02);
    chk("trig1_act",   8'(ch_active),  8'h02);
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk("trig1_hold_pulse", 8'(trig_pulse), 8'h00);
      chk("trig1_hold_act",   8'(ch_active),  8'h02);
    end
    trigger_in = 4'b0011;
    cyc(1);
    chk("trig0_pulse", 8'(trig_pulse), 8'h01);
    chk("trig0_act",   8'(ch_active),  8'h03);
    trigger_in = 4'b0010;
    cyc(1);
    chk("trig0_low_pulse", 8'(trig_pulse), 8'h00);
    trigger_in = 4'b0011; length_expire = 4'b0001;
    cyc(1);
    chk("coinc_pulse", 8'(trig_pulse), 8'h01);
    chk("coinc_act",   8'(ch_active),  8'h03);
    cyc(1);
    chk("expire0_act", 8'(ch_active),  8'h02);
    length_expire = 4'b0000;
    cyc(1);
    chk("idle_act", 8'(ch_active), 8'h02);
    length_expire = 4'b0010;
    cyc(1);
    chk("expire1_act", 8'(ch_active), 8'h00);
    length_expire = 4'b0000; trigger_in = 4'b0000;

    // Fresh reset for cycle-aligned sequencer checks
    reset = 1'b1; master_en = 1'b0;
    cyc(1);
    reset = 1'b0; master_en = 1'b1;

`ifdef APU_SEQ_EXT_TICK_EN
    begin
      int unsigned gaps [8] = '{1, 3, 2, 5, 1, 7, 4, 2};
      for (int i = 0; i < 8; i++) begin
        for (int g = 0; g < int'(gaps[i]); g++) begin
          cyc(1);
          chk("ext_idle_len",  8'(length_tick), 8'd0);
          chk("ext_idle_step", 8'(step), 8'(i));
        end
        tick_512_in = 1'b1;
        cyc(1);
        tick_512_in = 1'b0;
        chk("ext_step",  8'(step),        8'((i + 1) % 8));
        chk("ext_len",   8'(length_tick), 8'(i % 2 == 0));
        chk("ext_sweep", 8'(sweep_tick),  8'(i == 2 || i == 6));
        chk("ext_env",   8'(env_tick),    8'(i == 7));
      end
      // Tick with power off is ignored
      master_en = 1'b0; tick_512_in = 1'b1;
      cyc(1);
      tick_512_in = 1'b0;
      chk_all_zero("ext_off");
    end
`else
    // 40 powered cycles: tick every 4th edge, strobes from the executed step
    for (int c = 1; c <= 40; c++) begin
      cyc(1);
      begin
        bit tk;
        int s;
        tk = (c % 4 == 0);
        s  = (c / 4 + 7) % 8;
        chk("run_len",   8'(length_tick), 8'(tk && (s % 2 == 0)));
        chk("run_sweep", 8'(sweep_tick),  8'(tk && (s == 2 || s == 6)));
        chk("run_env",   8'(env_tick),    8'(tk && s == 7));
        chk("run_step",  8'(step),        8'((c / 4) % 8));
      end
    end

    // Power off mid-step 5 with all channels active
    trigger_in = 4'b1111;
    cyc(13);
    chk("pre_off_step", 8'(step),      8'd5);
    chk("pre_off_act",  8'(ch_active), 8'h0F);
    master_en = 1'b0;
    cyc(1);
    chk_all_zero("off");
    trigger_in = 4'b0000;
    cyc(2);
    trigger_in = 4'b0100;
    cyc(2);
    chk_all_zero("off_trig");

    // Power on with trigger already high: no edge, first tick after 4 cycles
    master_en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc(1);
      chk("on_len",  8'(length_tick), 8'(c == 4));
      chk("on_step", 8'(step),        8'(c == 4));
      chk("on_tpls", 8'(trig_pulse),  8'h00);
    end

    // Power drop coinciding with the step-2 tick suppresses it
    cyc(7);
    chk("supp_pre_step", 8'(step), 8'd2);
    master_en = 1'b0;
    cyc(1);
    chk("supp_len",   8'(length_tick), 8'd0);
    chk("supp_sweep", 8'(sweep_tick),  8'd0);
    chk("supp_step",  8'(step),        8'd0);

    // Reset at step 6 with a trigger edge pending
    master_en = 1'b1;
    cyc(25);
    chk("pre_rst_step", 8'(step), 8'd6);
    trigger_in = 4'b0111; reset = 1'b1;
    cyc(1);
    chk_all_zero("rst6");
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("post_rst_tpls", 8'(trig_pulse), 8'h07);
    chk("post_rst_act",  8'(ch_active),  8'h07);
    chk("post_rst_step", 8'(step),       8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
